// File: rtl/risc_v_32_wb_arbiter.sv
// risc_v_32_wb_arbiter: two-lane buffered writeback arbiter feeding the single register-file write port.
// Each lane has a circular FIFO; a round-robin grant drains one head per cycle into registered rf_* outputs.
module risc_v_32_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            l0_valid,
    output logic            l0_ready,
    input  logic [4:0]      l0_rd,
    input  logic [XLEN-1:0] l0_data,
    input  logic            l1_valid,
    output logic            l1_ready,
    input  logic [4:0]      l1_rd,
    input  logic [XLEN-1:0] l1_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]           valid, ready, push, pop, ne;
    logic [1:0][4:0]      in_rd, head_rd;
    logic [1:0][XLEN-1:0] in_data, head_data;
    logic                 gnt, sel, rr_q, rr_d, we_q;
    logic [4:0]           waddr_q;
    logic [XLEN-1:0]      wdata_q;

    assign valid   = {l1_valid, l0_valid};
    assign in_rd   = {l1_rd, l0_rd};
    assign in_data = {l1_data, l0_data};
    assign {l1_ready, l0_ready} = ready;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [AW-1:0]   rp_q, wp_q;
        logic [CW-1:0]   cnt_q;
        logic [4:0]      rd_mem   [DEPTH];
        logic [XLEN-1:0] data_mem [DEPTH];
        assign ready[g]     = (cnt_q < CW'(DEPTH)) && !flush;
        // x0 writes are acknowledged but never stored
        assign push[g]      = valid[g] && ready[g] && (in_rd[g] != 5'd0);
        assign pop[g]       = gnt && (sel == 1'(g));
        assign ne[g]        = cnt_q != '0;
        assign head_rd[g]   = rd_mem[rp_q];
        assign head_data[g] = data_mem[rp_q];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rp_q  <= '0;
                wp_q  <= '0;
                cnt_q <= '0;
            end else if (flush) begin
                rp_q  <= '0;
                wp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[g]) wp_q <= wp_q + AW'(1);
                if (pop[g]) rp_q <= rp_q + AW'(1);
                cnt_q <= cnt_q + CW'(push[g]) - CW'(pop[g]);
            end
        end
        always_ff @(posedge clk) begin
            if (push[g]) begin
                rd_mem[wp_q]   <= in_rd[g];
                data_mem[wp_q] <= in_data[g];
            end
        end
    end

    assign gnt  = |ne;
    assign sel  = &ne ? rr_q : ne[1];
    assign rr_d = gnt ? ~sel : rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (flush) begin
            rr_q <= 1'b0;
            we_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            we_q <= gnt;
            if (gnt) begin
                waddr_q <= head_rd[sel];
                wdata_q <= head_data[sel];
            end
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign busy     = (|ne) || we_q;
endmodule

// File: tb/tb_risc_v_32_wb_arbiter.sv
// tb_risc_v_32_wb_arbiter: directed checks of the writeback arbiter with DEPTH=2.
module tb_risc_v_32_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        l0_valid = 1'b0, l1_valid = 1'b0;
    logic        l0_ready, l1_ready;
    logic [4:0]  l0_rd = '0, l1_rd = '0;
    logic [31:0] l0_data = '0, l1_data = '0;
    logic        rf_we, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk = 0, n_err = 0, cyc = 0;
    logic [36:0] wlog [$];
    int          wcyc [$];

    risc_v_32_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .l0_valid(l0_valid), .l0_ready(l0_ready), .l0_rd(l0_rd), .l0_data(l0_data),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_rd(l1_rd), .l1_data(l1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            wlog.push_back({rf_waddr, rf_wdata});
            wcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic idle();
        l0_valid = 1'b0;
        l1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, k0, k1, i0, i1;
        logic a0, a1, l1_low;
        logic [36:0] q0 [$];
        logic [36:0] q1 [$];
        logic [36:0] exp_c [6];
        // reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy0", l0_ready, 1);
        chk("rst_rdy1", l1_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // single write: accepted in cycle 1, written in cycle 3
        l0_valid = 1'b1; l0_rd = 5'd5; l0_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("single_c2_we", rf_we, 0);
        chk("single_c2_busy", busy, 1);
        tick();
        chk("single_c3_we", rf_we, 1);
        chk("single_c3_addr", rf_waddr, 5);
        chk("single_c3_data", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("single_c4_we", rf_we, 0);
        chk("single_c4_busy", busy, 0);
        chk("single_c4_hold", rf_waddr, 5);

        // contention; flush first brings rr back to lane 0
        do_flush();
        s = wlog.size();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 20 && (k0 < 3 || k1 < 3); c++) begin
            l0_valid = k0 < 3; l0_rd = 5'(1 + k0); l0_data = 32'h10 + 32'(k0);
            l1_valid = k1 < 3; l1_rd = 5'(4 + k1); l1_data = 32'h20 + 32'(k1);
            #1;
            a0 = l0_valid && l0_ready;
            a1 = l1_valid && l1_ready;
            tick();
            if (a0) k0++;
            if (a1) k1++;
        end
        idle();
        repeat (8) tick();
        exp_c = '{{5'd1, 32'h10}, {5'd4, 32'h20}, {5'd2, 32'h11},
                  {5'd5, 32'h21}, {5'd3, 32'h12}, {5'd6, 32'h22}};
        chk("cont_nwrites", wlog.size() - s, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("cont_w%0d", i), (s + i < wlog.size()) ? wlog[s+i] : 37'h0, exp_c[i]);
        if (wlog.size() >= s + 6) chk("cont_consecutive", wcyc[s+5] - wcyc[s], 5);

        // both lanes fed every cycle: each fills then gets every other slot
        do_flush();
        s = wlog.size();
        k0 = 0; k1 = 0; l1_low = 1'b0;
        for (int c = 0; c < 12; c++) begin
            l0_valid = 1'b1; l0_rd = 5'(8 + k0 % 8);  l0_data = 32'h100 + 32'(k0);
            l1_valid = 1'b1; l1_rd = 5'(16 + k1 % 8); l1_data = 32'h200 + 32'(k1);
            #1;
            a0 = l0_ready;
            a1 = l1_ready;
            if (!a1) l1_low = 1'b1;
            if (a0) q0.push_back({l0_rd, l0_data});
            if (a1) q1.push_back({l1_rd, l1_data});
            tick();
            if (a0) k0++;
            if (a1) k1++;
        end
        idle();
        repeat (8) tick();
        chk("bp_acc0", k0, 7);
        chk("bp_acc1", k1, 7);
        chk("bp_l1_ready_dropped", l1_low, 1);
        chk("bp_nwrites", wlog.size() - s, 14);
        i0 = 0; i1 = 0;
        for (int i = s; i < wlog.size(); i++) begin
            if (wlog[i][9:8] == 2'd1) begin
                chk("bp_lane0_order", wlog[i], (i0 < q0.size()) ? q0[i0] : 37'h0);
                i0++;
            end else begin
                chk("bp_lane1_order", wlog[i], (i1 < q1.size()) ? q1[i1] : 37'h0);
                i1++;
            end
        end

        // x0 discard
        s = wlog.size();
        l0_valid = 1'b1; l0_rd = 5'd0; l0_data = 32'h1234;
        #1 chk("x0_ready", l0_ready, 1);
        tick();
        idle();
        chk("x0_busy_c2", busy, 0);
        repeat (2) tick();
        chk("x0_we", rf_we, 0);
        chk("x0_busy", busy, 0);
        chk("x0_nwrites", wlog.size() - s, 0);

        // flush with both FIFOs filling and inputs valid in the flush cycle
        s = wlog.size();
        l0_valid = 1'b1; l0_rd = 5'd7; l0_data = 32'hA0;
        l1_valid = 1'b1; l1_rd = 5'd9; l1_data = 32'hB0;
        tick();
        l0_data = 32'hA1; l1_data = 32'hB1;
        tick();
        flush = 1'b1; l0_data = 32'hEE; l1_data = 32'hEF;
        #1;
        chk("flush_rdy0", l0_ready, 0);
        chk("flush_rdy1", l1_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_we", rf_we, 0);
        chk("flush_busy", busy, 0);
        repeat (3) tick();
        chk("flush_nwrites", wlog.size() - s, 1);
        l0_valid = 1'b1; l0_rd = 5'd10; l0_data = 32'hC0;
        l1_valid = 1'b1; l1_rd = 5'd11; l1_data = 32'hD0;
        tick();
        idle();
        tick();
        chk("flush_rr_first", rf_waddr, 10);
        tick();
        chk("flush_rr_second", rf_waddr, 11);
        repeat (3) tick();

        // async reset with entries pending and a write in progress
        l0_valid = 1'b1; l0_rd = 5'd12; l0_data = 32'hE0;
        l1_valid = 1'b1; l1_rd = 5'd13; l1_data = 32'hF0;
        tick();
        l0_data = 32'hE1; l1_data = 32'hF1;
        tick();
        idle();
        chk("arst_pre_we", rf_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", rf_we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_waddr", rf_waddr, 0);
        s = wlog.size();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) tick();
        chk("arst_post_we", rf_we, 0);
        chk("arst_post_busy", busy, 0);
        chk("arst_nwrites", wlog.size() - s, 0);
        chk("arst_rdy0", l0_ready, 1);
        chk("arst_rdy1", l1_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
